serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: sequences one full_adder instance (ports a, b, c_in, sum, c_out) over WIDTH-bit operands, one bit per clock, LSB first.
- Owns the operand shift registers, carry flip-flop, bit counter and valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer wherever area matters more than add latency.

---
 rtl/serial_add_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder stepped LSB-first over WIDTH cycles, with valid/ready on both sides.
// Optional signed-overflow output out_ovf is built when SERIAL_ADD_OVF_EN is defined.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             out_ovf,
`endif
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_sum_q, out_sum_d;
   logic               out_cout_q, out_cout_d;
   logic               ovf_q, ovf_d;
   logic               fa_sum, fa_cout;

   full_adder u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      sum_sr_d    = sum_sr_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      ovf_d       = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d   = in_a;
               b_sr_d   = in_b;
               carry_d  = in_cin;
               cnt_d    = '0;
               sum_sr_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_sum_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
               out_cout_d  = fa_cout;
               // On the MSB step carry_q is exactly the carry into the MSB.
               ovf_d       = carry_q ^ fa_cout;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         sum_sr_q    <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         sum_sr_q    <= sum_sr_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign out_ovf   = ovf_q;
`else
   // Without the overflow port this flop has no load and is trimmed away.
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): results, latency, backpressure, async reset.
// Overflow checks are active when SERIAL_ADD_OVF_EN is defined.

module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_cout;
   logic       busy;
`ifdef SERIAL_ADD_OVF_EN
   logic       out_ovf;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
`ifdef SERIAL_ADD_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One add: accept, count edges to out_valid, optionally stall the consumer while
   // pulsing a stray request, then complete the handshake.
   task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] esum, input logic ecout,
                          input logic eovf, input int stall);
      int n;
      logic [7:0] held;
      @(negedge clk);
      check({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 8'hEE; in_b = 8'hDD; in_cin = 1'b1;
      n = 0;
      while (!out_valid && n < 40) begin
         check({tag, " busy run"}, {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, n, 32'd8);
      check({tag, " sum"}, {24'd0, out_sum}, {24'd0, esum});
      check({tag, " cout"}, {31'd0, out_cout}, {31'd0, ecout});
`ifdef SERIAL_ADD_OVF_EN
      check({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
`else
      if (eovf === 1'bx) $display("[TB] note: unknown ovf expectation");
`endif
      check({tag, " busy done"}, {31'd0, busy}, 32'd1);
      held = out_sum;
      for (int i = 0; i < stall; i++) begin
         in_a = 8'h11; in_b = 8'h00; in_cin = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
         check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, " hold sum"}, {24'd0, out_sum}, {24'd0, held});
         check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
      check({tag, " busy idle"}, {31'd0, busy}, 32'd0);
      $display("[TB] %s: %02h+%02h+%0d -> sum=%02h cout=%0d", tag, a, b, cin, held, out_cout);
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_cin = 1'b0; out_ready = 1'b1;
      #2;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset out_sum", {24'd0, out_sum}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk); rstn = 1'b1;

      run_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      run_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      run_add("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0);
      run_add("bp_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 5);
      // The stray 0x11 request must not have started anything.
      repeat (2) @(posedge clk);
      #1;
      check("dropped no valid", {31'd0, out_valid}, 32'd0);
      check("dropped no busy", {31'd0, busy}, 32'd0);
      check("dropped sum kept", {24'd0, out_sum}, 32'h46);

      // Reset in the middle of a RUN.
      @(negedge clk);
      in_a = 8'h3C; in_b = 8'h0F; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("midrun busy", {31'd0, busy}, 32'd1);
      rstn = 1'b0;
      #1;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_sum", {24'd0, out_sum}, 32'd0);
      check("rst out_cout", {31'd0, out_cout}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk); rstn = 1'b1;
      $display("[TB] reset mid-run: outputs cleared");
      run_add("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 0);

      run_add("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
      run_add("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
      run_add("10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
